// File: rtl/jtag_tap_driver_if.sv
// Request/response bundle between a scan client and the JTAG TAP driver.
// The client side uses the master modport, the driver the slave modport.
interface jtag_tap_driver_if;
   logic        req_valid_i;
   logic        req_ready_o;
   logic        req_is_ir_i;
   logic [6:0]  req_len_i;
   logic [63:0] req_data_i;
   logic        tap_reset_i;
   logic        rsp_valid_o;
   logic [63:0] rsp_data_o;

   modport master (
      output req_valid_i, req_is_ir_i, req_len_i, req_data_i, tap_reset_i,
      input  req_ready_o, rsp_valid_o, rsp_data_o
   );

   modport slave (
      input  req_valid_i, req_is_ir_i, req_len_i, req_data_i, tap_reset_i,
      output req_ready_o, rsp_valid_o, rsp_data_o
   );
endinterface

// File: rtl/jtag_tap_driver.sv
// JTAG TAP driver: turns one IR/DR scan request into a TCK/TMS/TDI sequence
// that starts and ends in Run-Test/Idle, and returns the captured TDO bits.
module jtag_tap_driver #(
   parameter int unsigned CLK_DIV = 4
) (
   input  logic             clk_i,
   input  logic             rst_i,
   jtag_tap_driver_if.slave bus,
   output logic             jtag_tck_o,
   output logic             jtag_tms_o,
   output logic             jtag_tdi_o,
   output logic             jtag_trst_no,
   input  logic             jtag_td_i
);

   typedef enum logic [2:0] {INIT, IDLE, NAV, SHIFT, EXIT, RESP} state_e;

   localparam logic [7:0] DIV_LAST = 8'(CLK_DIV - 1);

   state_e      state_q, state_d;
   logic        tck_q, tck_d;
   logic        tms_q, tms_d;
   logic        tdi_q, tdi_d;
   logic        trst_q;
   logic [7:0]  div_q, div_d;
   logic [6:0]  bit_q, bit_d;
   logic        is_ir_q, is_ir_d;
   logic [6:0]  len_q, len_d;
   logic [63:0] data_q, data_d;
   logic [63:0] cap_q, cap_d;
   logic [63:0] rsp_q, rsp_d;

   logic       active, wrap, tck_rise, tck_fall;
   logic [6:0] nav_last, shift_last, len_eff;
   logic [5:0] shift_nxt;

   // Every TCK period is a high phase followed by a low phase; a fresh sequence
   // preloads the divider so the first rise follows a short low setup phase.
   assign active     = (state_q == INIT) || (state_q == NAV) ||
                       (state_q == SHIFT) || (state_q == EXIT);
   assign wrap       = (div_q == DIV_LAST);
   assign tck_rise   = active && wrap && !tck_q;
   assign tck_fall   = active && wrap && tck_q;
   assign nav_last   = is_ir_q ? 7'd3 : 7'd2;
   assign shift_last = len_q - 7'd1;
   assign shift_nxt  = bit_q[5:0] + 6'd1;

   always_comb begin
      if (bus.req_len_i == 7'd0)
         len_eff = 7'd1;
      else if (bus.req_len_i > 7'd64)
         len_eff = 7'd64;
      else
         len_eff = bus.req_len_i;
   end

   always_comb begin
      // NOTE: every register's next value defaults to its current value first, so no branch can infer a latch.
      state_d = state_q;
      tck_d   = tck_q;
      tms_d   = tms_q;
      tdi_d   = tdi_q;
      div_d   = div_q;
      bit_d   = bit_q;
      is_ir_d = is_ir_q;
      len_d   = len_q;
      data_d  = data_q;
      cap_d   = cap_q;
      rsp_d   = rsp_q;

      if (active) begin
         if (wrap) begin
            div_d = 8'd0;
            tck_d = !tck_q;
         end else begin
            div_d = div_q + 8'd1;
         end
      end

      case (state_q)
         INIT: begin
            // Five TMS=1 periods reach Test-Logic-Reset, the sixth (TMS=0) Run-Test/Idle.
            if (tck_fall) begin
               if (bit_q == 7'd5) begin
                  state_d = IDLE;
                  tms_d   = 1'b0;
                  bit_d   = 7'd0;
               end else begin
                  bit_d = bit_q + 7'd1;
                  tms_d = (bit_q < 7'd4);
               end
            end
         end

         IDLE: begin
            if (bus.tap_reset_i) begin
               state_d = INIT;
               tms_d   = 1'b1;
               tdi_d   = 1'b0;
               div_d   = DIV_LAST;
               bit_d   = 7'd0;
            end else if (bus.req_valid_i) begin
               state_d = NAV;
               is_ir_d = bus.req_is_ir_i;
               len_d   = len_eff;
               data_d  = bus.req_data_i;
               cap_d   = '0;
               tms_d   = 1'b1;
               tdi_d   = 1'b0;
               div_d   = DIV_LAST;
               bit_d   = 7'd0;
            end
         end

         NAV: begin
            if (tck_fall) begin
               if (bit_q == nav_last) begin
                  state_d = SHIFT;
                  bit_d   = 7'd0;
                  tdi_d   = data_q[0];
                  tms_d   = (len_q == 7'd1);
               end else begin
                  bit_d = bit_q + 7'd1;
                  tms_d = is_ir_q && (bit_q == 7'd0);
               end
            end
         end

         SHIFT: begin
            if (tck_rise)
               cap_d[bit_q[5:0]] = jtag_td_i;
            if (tck_fall) begin
               if (bit_q == shift_last) begin
                  state_d = EXIT;
                  bit_d   = 7'd0;
                  tms_d   = 1'b1;
                  tdi_d   = 1'b0;
               end else begin
                  bit_d = bit_q + 7'd1;
                  tdi_d = data_q[shift_nxt];
                  tms_d = ((bit_q + 7'd1) == shift_last);
               end
            end
         end

         EXIT: begin
            // bit_q==2 marks both exit periods done; leave one cycle after the last fall.
            if (bit_q == 7'd2) begin
               state_d = RESP;
               bit_d   = 7'd0;
               rsp_d   = cap_q;
            end else if (tck_fall) begin
               bit_d = bit_q + 7'd1;
               tms_d = 1'b0;
            end
         end

         RESP: begin
            state_d = IDLE;
         end

         default: begin
            state_d = INIT;
         end
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments only; data registers are reset too so outputs are defined from time zero.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q <= INIT;
         tck_q   <= 1'b0;
         tms_q   <= 1'b1;
         tdi_q   <= 1'b0;
         trst_q  <= 1'b0;
         div_q   <= 8'd0;
         bit_q   <= 7'd0;
         is_ir_q <= 1'b0;
         len_q   <= 7'd0;
         data_q  <= '0;
         cap_q   <= '0;
         rsp_q   <= '0;
      end else begin
         state_q <= state_d;
         tck_q   <= tck_d;
         tms_q   <= tms_d;
         tdi_q   <= tdi_d;
         trst_q  <= 1'b1;
         div_q   <= div_d;
         bit_q   <= bit_d;
         is_ir_q <= is_ir_d;
         len_q   <= len_d;
         data_q  <= data_d;
         cap_q   <= cap_d;
         rsp_q   <= rsp_d;
      end
   end

   assign jtag_tck_o      = tck_q;
   assign jtag_tms_o      = tms_q;
   assign jtag_tdi_o      = tdi_q;
   assign jtag_trst_no    = trst_q;
   assign bus.req_ready_o = (state_q == IDLE);
   assign bus.rsp_valid_o = (state_q == RESP);
   assign bus.rsp_data_o  = rsp_q;

endmodule

// File: tb/tb_jtag_tap_driver.sv
// Bench for jtag_tap_driver: a behavioural IEEE 1149.1 target (1-bit DR, 5-bit IR)
// answers the scans, and expected results come from the scan rules directly.
module tb_jtag_tap_driver;
   localparam int D = 4;

   logic clk_i = 1'b0;
   logic rst_i = 1'b1;
   logic tck, tms, tdi, trst_n;
   logic tdo = 1'b0;

   jtag_tap_driver_if bus();

   jtag_tap_driver #(.CLK_DIV(D)) dut (
      .clk_i       (clk_i),
      .rst_i       (rst_i),
      .bus         (bus),
      .jtag_tck_o  (tck),
      .jtag_tms_o  (tms),
      .jtag_tdi_o  (tdi),
      .jtag_trst_no(trst_n),
      .jtag_td_i   (tdo)
   );

   always #5 clk_i = ~clk_i;

   int checks = 0;
   int fails  = 0;

   task automatic check(input string tag, input logic [127:0] act, input logic [127:0] exp);
      checks++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h", tag, act, exp);
      end
   endtask

   // ---------------- target TAP model ----------------
   typedef enum logic [3:0] {TLR, RTI, SEL_DR, CAP_DR, SH_DR, EX1_DR, PA_DR, EX2_DR, UPD_DR,
                             SEL_IR, CAP_IR, SH_IR, EX1_IR, PA_IR, EX2_IR, UPD_IR} tap_e;

   function automatic tap_e tap_next(input tap_e s, input logic m);
      case (s)
         TLR:     return m ? TLR    : RTI;
         RTI:     return m ? SEL_DR : RTI;
         SEL_DR:  return m ? SEL_IR : CAP_DR;
         CAP_DR:  return m ? EX1_DR : SH_DR;
         SH_DR:   return m ? EX1_DR : SH_DR;
         EX1_DR:  return m ? UPD_DR : PA_DR;
         PA_DR:   return m ? EX2_DR : PA_DR;
         EX2_DR:  return m ? UPD_DR : SH_DR;
         UPD_DR:  return m ? SEL_DR : RTI;
         SEL_IR:  return m ? TLR    : CAP_IR;
         CAP_IR:  return m ? EX1_IR : SH_IR;
         SH_IR:   return m ? EX1_IR : SH_IR;
         EX1_IR:  return m ? UPD_IR : PA_IR;
         PA_IR:   return m ? EX2_IR : PA_IR;
         EX2_IR:  return m ? UPD_IR : SH_IR;
         UPD_IR:  return m ? SEL_DR : RTI;
         default: return TLR;
      endcase
   endfunction

   tap_e       tap_st = TLR;
   logic       dr_bit = 1'b0;
   logic       dr_cap_bit = 1'b0;
   logic [4:0] ir_sr = 5'd0;

   always @(posedge tck or negedge trst_n) begin
      if (!trst_n) begin
         tap_st <= TLR;
      end else begin
         if (tap_st == CAP_DR) dr_bit <= dr_cap_bit;
         if (tap_st == SH_DR)  dr_bit <= tdi;
         if (tap_st == CAP_IR) ir_sr  <= 5'b00001;
         if (tap_st == SH_IR)  ir_sr  <= {tdi, ir_sr[4:1]};
         tap_st <= tap_next(tap_st, tms);
      end
   end

   always @(negedge tck)
      tdo <= (tap_st == SH_DR) ? dr_bit : (tap_st == SH_IR) ? ir_sr[0] : 1'b0;

   // ---------------- pin monitors ----------------
   int           period_cnt = 0;
   logic [127:0] obs_tms = '0;
   logic [127:0] obs_tdi = '0;

   always @(posedge tck) begin
      if (period_cnt < 128) begin
         obs_tms[period_cnt] = tms;
         obs_tdi[period_cnt] = tdi;
      end
      period_cnt++;
   end

   int   cyc = 0;
   int   last_fall = 0;
   int   hi_len = 0;
   int   bad_high = 0;
   int   bad_edge = 0;
   int   bad_pulse = 0;
   int   rsp_cnt = 0;
   logic p_tck = 1'b0, p_tms = 1'b1, p_tdi = 1'b0, p_rsp = 1'b0;

   always @(posedge clk_i) cyc++;

   always @(negedge clk_i) begin
      if (tck) begin
         hi_len++;
      end else begin
         if (p_tck) begin
            if (!rst_i && hi_len != D) bad_high++;
            last_fall = cyc;
         end
         hi_len = 0;
      end
      if (!rst_i && tck && (tms !== p_tms || tdi !== p_tdi)) bad_edge++;
      if (bus.rsp_valid_o) begin
         rsp_cnt++;
         if (p_rsp) bad_pulse++;
      end
      p_tck = tck;
      p_tms = tms;
      p_tdi = tdi;
      p_rsp = bus.rsp_valid_o;
   end

   // ---------------- helpers ----------------
   logic [63:0] last_rsp = '0;

   function automatic logic [63:0] lmask(input int len);
      logic [63:0] one;
      one = 64'd1;
      return (len >= 64) ? '1 : ((one << len) - 64'd1);
   endfunction

   task automatic reset_value_check(input string tag);
      check({tag, "_tck"},   tck, 0);
      check({tag, "_tms"},   tms, 1);
      check({tag, "_tdi"},   tdi, 0);
      check({tag, "_trst"},  trst_n, 0);
      check({tag, "_ready"}, bus.req_ready_o, 0);
      check({tag, "_rspv"},  bus.rsp_valid_o, 0);
      check({tag, "_rspd"},  bus.rsp_data_o, 0);
   endtask

   task automatic init_check(input string tag, input int t0);
      int t;
      t = t0;
      while (!bus.req_ready_o && t < 200) begin
         @(negedge clk_i);
         t++;
      end
      check({tag, "_ready_lat"}, (bus.req_ready_o && t <= 12 * D + 2), 1);
      check({tag, "_tck_periods"}, period_cnt, 6);
      check({tag, "_tms_seq"}, obs_tms, 128'h1F);
      check({tag, "_tap_rti"}, tap_st, RTI);
   endtask

   task automatic do_scan(input bit is_ir, input logic [6:0] len, input logic [63:0] data,
                          input bit cap_bit);
      int           l, nav, t;
      logic [127:0] etms, etdi;
      logic [63:0]  exp;
      l   = (len == 0) ? 1 : (len > 64) ? 64 : int'(len);
      nav = is_ir ? 4 : 3;
      dr_cap_bit = cap_bit;
      exp  = is_ir ? (((data << 5) | 64'h1) & lmask(l))
                   : (((data << 1) | 64'(cap_bit)) & lmask(l));
      etms = '0;
      etms[0] = 1'b1;
      if (is_ir) etms[1] = 1'b1;
      etms[nav + l - 1] = 1'b1;
      etms[nav + l]     = 1'b1;
      etdi = '0;
      for (int i = 0; i < l; i++) etdi[nav + i] = data[i];

      t = 0;
      while (!bus.req_ready_o && t < 200) begin
         @(negedge clk_i);
         t++;
      end
      check("scan_ready", bus.req_ready_o, 1);
      check("rsp_hold", bus.rsp_data_o, last_rsp);

      bus.req_valid_i = 1'b1;
      bus.req_is_ir_i = is_ir;
      bus.req_len_i   = len;
      bus.req_data_i  = data;
      @(posedge clk_i);
      #1;
      period_cnt = 0;
      obs_tms = '0;
      obs_tdi = '0;
      bus.req_valid_i = 1'b0;
      bus.req_is_ir_i = ~is_ir;
      bus.req_len_i   = 7'($urandom);
      bus.req_data_i  = {$urandom, $urandom};
      @(negedge clk_i);
      check("ready_drop", bus.req_ready_o, 0);

      t = 0;
      while (!bus.rsp_valid_o && t < 2000) begin
         @(negedge clk_i);
         t++;
      end
      check("rsp_seen", bus.rsp_valid_o, 1);
      check("rsp_data", bus.rsp_data_o, exp);
      check("rsp_lat", cyc - last_fall, 1);
      check("tck_periods", period_cnt, l + nav + 2);
      check("tms_seq", obs_tms, etms);
      check("tdi_seq", obs_tdi, etdi);
      @(negedge clk_i);
      check("rsp_pulse_end", bus.rsp_valid_o, 0);
      check("idle_return", bus.req_ready_o, 1);
      check("tap_rti", tap_st, RTI);
      last_rsp = exp;
   endtask

   initial begin
      #800000;
      $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
      $fatal(1);
   end

   // ---------------- stimulus ----------------
   initial begin
      int          t, rsp0, r;
      logic [6:0]  len;
      bus.req_valid_i = 1'b0;
      bus.req_is_ir_i = 1'b0;
      bus.req_len_i   = 7'd0;
      bus.req_data_i  = '0;
      bus.tap_reset_i = 1'b0;

      repeat (3) @(negedge clk_i);
      reset_value_check("rst");
      period_cnt = 0;
      obs_tms = '0;
      rst_i = 1'b0;
      @(negedge clk_i);
      check("trst_release", trst_n, 1);
      init_check("por", 1);

      do_scan(1'b0, 7'd32, 64'hDEADBEEF, 1'b1);
      do_scan(1'b1, 7'd5, 64'h01, 1'b0);
      do_scan(1'b0, 7'd0, {$urandom, $urandom}, 1'b1);
      do_scan(1'b0, 7'd100, {$urandom, $urandom}, 1'b0);

      // tap_reset_i together with a request: the reset wins
      rsp0 = rsp_cnt;
      bus.tap_reset_i = 1'b1;
      bus.req_valid_i = 1'b1;
      bus.req_is_ir_i = 1'b0;
      bus.req_len_i   = 7'd8;
      bus.req_data_i  = {$urandom, $urandom};
      @(posedge clk_i);
      #1;
      bus.tap_reset_i = 1'b0;
      bus.req_valid_i = 1'b0;
      period_cnt = 0;
      obs_tms = '0;
      @(negedge clk_i);
      check("tr_ready_low", bus.req_ready_o, 0);
      init_check("tr", 1);
      check("tr_no_rsp", rsp_cnt, rsp0);
      check("tr_rsp_hold", bus.rsp_data_o, last_rsp);

      for (int n = 0; n < 16; n++) begin
         r = $urandom_range(0, 9);
         if (r == 0)      len = 7'd0;
         else if (r == 1) len = 7'd64;
         else if (r == 2) len = 7'($urandom_range(65, 127));
         else             len = 7'($urandom_range(1, 63));
         do_scan(1'($urandom_range(0, 1)), len, {$urandom, $urandom}, 1'($urandom_range(0, 1)));
      end

      // asynchronous reset during shift bit 10 of a DR scan
      bus.req_valid_i = 1'b1;
      bus.req_is_ir_i = 1'b0;
      bus.req_len_i   = 7'd40;
      bus.req_data_i  = {$urandom, $urandom} | 64'h1;
      @(posedge clk_i);
      #1;
      bus.req_valid_i = 1'b0;
      period_cnt = 0;
      rsp0 = rsp_cnt;
      t = 0;
      while (period_cnt < 14 && t < 600) begin
         @(posedge clk_i);
         #1;
         t++;
      end
      check("mid_reached_bit10", (period_cnt >= 14), 1);
      #2;
      rst_i = 1'b1;
      #1;
      reset_value_check("mid_rst");
      period_cnt = 0;
      obs_tms = '0;
      last_rsp = '0;
      repeat (4) @(negedge clk_i);
      rst_i = 1'b0;
      @(negedge clk_i);
      check("mid_trst_release", trst_n, 1);
      init_check("mid", 1);
      check("mid_no_rsp", rsp_cnt, rsp0);

      do_scan(1'b1, 7'd12, {$urandom, $urandom}, 1'b0);

      check("tck_high_phase_len", bad_high, 0);
      check("pin_change_while_tck_high", bad_edge, 0);
      check("rsp_pulse_width", bad_pulse, 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
      $finish;
   end

endmodule

// File: doc/jtag_tap_driver.md
JTAG_TAP_DRIVER -- requirements
Module: jtag_tap_driver

Interface
REQ-001 SHALL have parameter CLK_DIV, default 4: clk_i cycles per TCK half-period; legal range 2..255.
REQ-002 SHALL have port clk_i  input  1  system clock; all logic runs on its rising edge.
REQ-003 SHALL have port rst_i  input  1  reset, asynchronous and active-high.
REQ-004 SHALL have port req_valid_i  input  1  scan request valid.
REQ-005 SHALL have port req_ready_o  output  1  driver idle and able to accept a request.
REQ-006 SHALL have port req_is_ir_i  input  1  1 = IR scan, 0 = DR scan.
REQ-007 SHALL have port req_len_i  input  7  number of bits to shift.
REQ-008 SHALL have port req_data_i  input  64  TDI data, shifted out LSB first.
REQ-009 SHALL have port tap_reset_i  input  1  request a TAP return to Test-Logic-Reset.
REQ-010 SHALL have port rsp_valid_o  output  1  single-cycle pulse; scan complete.
REQ-011 SHALL have port rsp_data_o  output  64  captured TDO bits.
REQ-012 SHALL have ports jtag_tck_o, jtag_tms_o, jtag_tdi_o, jtag_trst_no  output  1 each  JTAG pins driven into the target.
REQ-013 SHALL have port jtag_td_i  input  1  TDO returned from the target.

Function
REQ-014 SHALL generate TCK with a divider: high for CLK_DIV cycles, then low for CLK_DIV cycles; TCK is held low in IDLE.
REQ-015 SHALL change TMS and TDI only in the clk_i cycle in which TCK falls, or at the start of the first low phase.
REQ-016 SHALL sample jtag_td_i in the clk_i cycle in which TCK rises.
REQ-017 SHALL use the states INIT, IDLE, NAV, SHIFT, EXIT, RESP.
REQ-018 In INIT, SHALL issue 5 TCK periods with TMS=1, then 1 period with TMS=0, then enter IDLE (Run-Test/Idle).
REQ-019 SHALL assert req_ready_o only in IDLE; a request is accepted when req_valid_i and req_ready_o are both 1, and req_ready_o drops the next cycle.
REQ-020 On acceptance, SHALL register req_is_ir_i, req_len_i and req_data_i; later input changes have no effect.
REQ-021 NAV SHALL apply TMS 1,0,0 for a DR scan and 1,1,0,0 for an IR scan, reaching Shift.
REQ-022 SHIFT SHALL drive len bits on TDI, LSB first; TMS=1 on the last bit only (enter Exit1).
REQ-023 EXIT SHALL apply TMS=1 (Update), then TMS=0 (Run-Test/Idle), with TDI=0.
REQ-024 Total TCK periods per request SHALL be len+5 for DR and len+6 for IR.
REQ-025 Effective len SHALL be 1 when req_len_i=0, and 64 when req_len_i>64.
REQ-026 TDO bit sampled on shift bit i SHALL land in rsp_data_o[i]; bits at index len and above SHALL be 0.
REQ-027 In RESP, SHALL pulse rsp_valid_o for exactly 1 cycle, in the cycle after the last TCK falling edge.
REQ-028 rsp_data_o SHALL hold its value until the next rsp_valid_o; return to IDLE SHALL occur in the cycle after RESP.
REQ-029 tap_reset_i sampled high in IDLE SHALL re-run the INIT sequence, with req_ready_o low.
REQ-030 If tap_reset_i and req_valid_i are high together, tap_reset_i SHALL win and the request SHALL NOT be accepted.
REQ-031 tap_reset_i outside IDLE SHALL be ignored; there is no response back-pressure.

Reset
REQ-032 While rst_i=1: jtag_tck_o=0, jtag_tms_o=1, jtag_tdi_o=0, jtag_trst_no=0, req_ready_o=0, rsp_valid_o=0, rsp_data_o=0, state=INIT.
REQ-033 rst_i asserted mid-scan SHALL abort the scan immediately with no rsp_valid_o pulse.
REQ-034 jtag_trst_no SHALL rise in the first clk_i cycle after rst_i deasserts; the INIT sequence SHALL then run.
REQ-035 req_ready_o SHALL first rise 12*CLK_DIV+2 cycles or fewer after rst_i deasserts.

Verification
REQ-036 Reset release, CLK_DIV=4 -> 5 TCK periods with TMS=1, 1 with TMS=0; req_ready_o rises within 50 cycles.
REQ-037 DR scan, len=32, data=0xDEADBEEF, target model loops TDI back to TDO with 1 bit delay -> TMS 1,0,0, then 31x0, 1, then 1, 0; 37 TCK periods; rsp_data_o=0xDEADBEEF<<1 with bit0 from the capture value, upper bits 0.
REQ-038 IR scan, len=5, data=0x01, target IR captures 0b00001 -> 11 TCK periods; TDI sequence 1,0,0,0,0; rsp_data_o=0x01.
REQ-039 req_len_i=0, then req_len_i=100 -> both scans shift 1 and 64 bits respectively; TCK counts 6 and 69.
REQ-040 tap_reset_i and req_valid_i high together in IDLE -> no acceptance, INIT sequence runs, then req_ready_o returns.
REQ-041 rst_i pulsed during SHIFT bit 10 -> outputs take reset values asynchronously; no rsp_valid_o; the INIT sequence restarts after release.
